// File: rtl/uart_tx_packet_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_packet_framer
// Producer-side packet framer for the framed UART TX wrapper (head/tail/
// length-FIFO variant), fifo_uart_tx_clk domain. Wraps a payload byte stream
// as HEAD(2) LEN(2) PAYLOAD(L) [CSUM(1)] TAIL(2), one byte per cycle, and
// drives the wrapper's start/end strobes plus its wren/wren_r1 pair so the
// wrapper's length FIFO counts exactly the frame's byte total.
//
// Build option:
//   UART_FRAMER_CHECKSUM_EN  defined   -> 8-bit checksum byte after payload
//                            undefined -> TAIL follows the payload directly
//
// Ports:
//   fifo_uart_tx_clk        in   clock
//   rst_n_i                 in   async active-low reset
//   pkt_start_i             in   frame request strobe, samples pkt_len_i
//   pkt_len_i[15:0]         in   payload length L (1..MAX_LEN)
//   s_data_i[7:0]           in   payload byte
//   s_valid_i               in   payload byte valid
//   s_ready_o               out  payload byte accepted when valid&ready
//   fifo_uart_tx_prog_full  in   wrapper FIFO back-pressure
//   uart_tx_wren_start      out  frame-start strobe
//   fifo_uart_tx_wren       out  byte-emit pulse (counted by the wrapper)
//   fifo_uart_tx_wren_r1    out  wren delayed one cycle (data write)
//   fifo_uart_tx_data[7:0]  out  byte aligned with fifo_uart_tx_wren_r1
//   uart_tx_wren_end        out  frame-end strobe, with the last wren_r1
//   busy_o                  out  frame in progress
//   err_len_o               out  start rejected because of an illegal length
// ---------------------------------------------------------------------------
module uart_tx_packet_framer #(
   parameter logic [15:0] HEAD_WORD = 16'hEB90,
   parameter logic [15:0] TAIL_WORD = 16'h0D0A,
   parameter int unsigned MAX_LEN   = 1024
) (
   input  logic        fifo_uart_tx_clk,
   input  logic        rst_n_i,
   input  logic        pkt_start_i,
   input  logic [15:0] pkt_len_i,
   input  logic [7:0]  s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   input  logic        fifo_uart_tx_prog_full,
   output logic        uart_tx_wren_start,
   output logic        fifo_uart_tx_wren,
   output logic        fifo_uart_tx_wren_r1,
   output logic [7:0]  fifo_uart_tx_data,
   output logic        uart_tx_wren_end,
   output logic        busy_o,
   output logic        err_len_o
);

   localparam int unsigned LEN_W  = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_HEAD0,
      ST_HEAD1,
      ST_LEN0,
      ST_LEN1,
      ST_PAY,
`ifdef UART_FRAMER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_TAIL0,
      ST_TAIL1,
      ST_END
   } state_t;

   state_t              state_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt_q;
   logic [BYTE_W-1:0]   stage_q;
   logic [BYTE_W-1:0]   data_q;
   logic                wren_q;
   logic                wren_r1_q;
   logic                start_q;
   logic                end_q;
   logic                busy_q;
   logic                err_q;
`ifdef UART_FRAMER_CHECKSUM_EN
   logic [BYTE_W-1:0]   csum_q;
`endif

   logic                len_ok_c;
   logic                ready_c;
   logic                pay_acc_c;
   logic                last_pay_c;
   logic                emit_c;
   logic [BYTE_W-1:0]   byte_c;
   state_t              after_pay_c;

   // Length legality, payload handshake and the byte offered in each state
   always_comb begin
      len_ok_c    = 1'b0;
      ready_c     = 1'b0;
      pay_acc_c   = 1'b0;
      last_pay_c  = 1'b0;
      emit_c      = 1'b0;
      byte_c      = '0;
      after_pay_c = ST_TAIL0;

      len_ok_c   = (pkt_len_i != '0) && (pkt_len_i <= LEN_W'(MAX_LEN));
      ready_c    = (state_q == ST_PAY) && !fifo_uart_tx_prog_full;
      pay_acc_c  = ready_c && s_valid_i;
      // Leaving PAY on the L-th accept keeps ready low once the count reaches L
      last_pay_c = (cnt_q == (len_q - LEN_W'(1)));
`ifdef UART_FRAMER_CHECKSUM_EN
      after_pay_c = ST_CSUM;
`endif

      case (state_q)
         ST_HEAD0: begin byte_c = HEAD_WORD[15:8]; emit_c = !fifo_uart_tx_prog_full; end
         ST_HEAD1: begin byte_c = HEAD_WORD[7:0];  emit_c = !fifo_uart_tx_prog_full; end
         ST_LEN0:  begin byte_c = len_q[15:8];     emit_c = !fifo_uart_tx_prog_full; end
         ST_LEN1:  begin byte_c = len_q[7:0];      emit_c = !fifo_uart_tx_prog_full; end
         ST_PAY:   begin byte_c = s_data_i;        emit_c = pay_acc_c;               end
`ifdef UART_FRAMER_CHECKSUM_EN
         ST_CSUM:  begin byte_c = csum_q;          emit_c = !fifo_uart_tx_prog_full; end
`endif
         ST_TAIL0: begin byte_c = TAIL_WORD[15:8]; emit_c = !fifo_uart_tx_prog_full; end
         ST_TAIL1: begin byte_c = TAIL_WORD[7:0];  emit_c = !fifo_uart_tx_prog_full; end
         default:  begin byte_c = '0;              emit_c = 1'b0;                    end
      endcase
   end

   // Frame sequencer, emit pipeline (stage -> wren -> wren_r1/data) and strobes
   always_ff @(posedge fifo_uart_tx_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         stage_q   <= '0;
         data_q    <= '0;
         wren_q    <= 1'b0;
         wren_r1_q <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef UART_FRAMER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         err_q     <= 1'b0;
         wren_q    <= emit_c;
         wren_r1_q <= wren_q;
         if (emit_c) begin
            stage_q <= byte_c;
         end
         if (wren_q) begin
            data_q <= stage_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (pkt_start_i) begin
                  if (len_ok_c) begin
                     len_q   <= pkt_len_i;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_START;
`ifdef UART_FRAMER_CHECKSUM_EN
                     csum_q  <= pkt_len_i[15:8] + pkt_len_i[7:0];
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            // Start strobe lands one cycle ahead of the first possible wren
            ST_START: begin
               start_q <= 1'b1;
               state_q <= ST_HEAD0;
            end
            ST_HEAD0: if (emit_c) state_q <= ST_HEAD1;
            ST_HEAD1: if (emit_c) state_q <= ST_LEN0;
            ST_LEN0:  if (emit_c) state_q <= ST_LEN1;
            ST_LEN1:  if (emit_c) state_q <= ST_PAY;
            ST_PAY: begin
               if (pay_acc_c) begin
                  cnt_q <= cnt_q + LEN_W'(1);
`ifdef UART_FRAMER_CHECKSUM_EN
                  csum_q <= csum_q + s_data_i;
`endif
                  if (last_pay_c) begin
                     state_q <= after_pay_c;
                  end
               end
            end
`ifdef UART_FRAMER_CHECKSUM_EN
            ST_CSUM:  if (emit_c) state_q <= ST_TAIL0;
`endif
            ST_TAIL0: if (emit_c) state_q <= ST_TAIL1;
            ST_TAIL1: if (emit_c) state_q <= ST_END;
            // Last byte's wren is live here, so end_q rises with its wren_r1
            ST_END: begin
               end_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_ready_o            = ready_c;
   assign uart_tx_wren_start   = start_q;
   assign fifo_uart_tx_wren    = wren_q;
   assign fifo_uart_tx_wren_r1 = wren_r1_q;
   assign fifo_uart_tx_data    = data_q;
   assign uart_tx_wren_end     = end_q;
   assign busy_o               = busy_q;
   assign err_len_o            = err_q;

endmodule

// File: tb/tb_uart_tx_packet_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_packet_framer
// Directed/randomized bench for uart_tx_packet_framer. Expected frames are
// built from the framing rules (header, length, payload, optional sum,
// tail); a negedge monitor collects what the DUT writes and strobes.
// ---------------------------------------------------------------------------
module tb_uart_tx_packet_framer;

   logic        clk;
   logic        rst_n;
   logic        pkt_start;
   logic [15:0] pkt_len;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        prog_full;
   logic        wr_start;
   logic        wren;
   logic        wren_r1;
   logic [7:0]  tx_data;
   logic        wr_end;
   logic        busy;
   logic        err_len;

   int total = 0;
   int bad   = 0;

   // monitor state
   logic [7:0] cap_q[$];
   int cyc = 0;
   int wren_cnt = 0, start_cnt = 0, end_cnt = 0, err_cnt = 0, busy_cyc = 0;
   int end_pos = -1, end_viol = 0, pf_viol = 0;
   int start_cyc = -1, first_wren_cyc = -1;
   bit pf_prev = 1'b0;

   logic [7:0] fixed_pay[$];
   logic [7:0] exp_q[$];

   uart_tx_packet_framer dut (
      .fifo_uart_tx_clk       (clk),
      .rst_n_i                (rst_n),
      .pkt_start_i            (pkt_start),
      .pkt_len_i              (pkt_len),
      .s_data_i               (s_data),
      .s_valid_i              (s_valid),
      .s_ready_o              (s_ready),
      .fifo_uart_tx_prog_full (prog_full),
      .uart_tx_wren_start     (wr_start),
      .fifo_uart_tx_wren      (wren),
      .fifo_uart_tx_wren_r1   (wren_r1),
      .fifo_uart_tx_data      (tx_data),
      .uart_tx_wren_end       (wr_end),
      .busy_o                 (busy),
      .err_len_o              (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe the wrapper-facing side once per cycle, away from the edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (wren_r1) cap_q.push_back(tx_data);
         if (wren) begin
            wren_cnt++;
            if (first_wren_cyc < 0) first_wren_cyc = cyc;
            if (pf_prev) pf_viol++;
         end
         if (wr_start) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (wr_end) begin
            end_cnt++;
            end_pos = cap_q.size();
            if (!wren_r1 || wren) end_viol++;
         end
         if (err_len) err_cnt++;
         if (busy) busy_cyc++;
         pf_prev = prog_full;
      end else begin
         pf_prev = 1'b0;
      end
      cyc++;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"},   longint'(wr_start), 0);
      check({tag, "_wren"},    longint'(wren),     0);
      check({tag, "_wren_r1"}, longint'(wren_r1),  0);
      check({tag, "_data"},    longint'(tx_data),  0);
      check({tag, "_end"},     longint'(wr_end),   0);
      check({tag, "_busy"},    longint'(busy),     0);
      check({tag, "_err"},     longint'(err_len),  0);
      check({tag, "_ready"},   longint'(s_ready),  0);
   endtask

   // Run one frame request. pf_after: bytes seen before a 5-cycle prog_full
   // window (-1 none); mid_cyc: cycle of an extra start pulse (-1 none);
   // abort_after: payload bytes accepted before reset is pulled (-1 none).
   task automatic run_frame(input string tag, input int len, input bit gaps,
                            input int pf_after, input int mid_cyc, input int abort_after);
      logic [7:0] pay[$];
      int s0, e0, w0, err0, ev0, pv0;
      int idx, gap_left, pf_left, cyc_f, sum;
      bit pf_done, done, acc;

      pay.delete();
      for (int i = 0; i < len; i++) begin
         if (i < fixed_pay.size()) pay.push_back(fixed_pay[i]);
         else pay.push_back(8'($urandom_range(0, 255)));
      end

      // Expected byte stream from the framing rules
      exp_q.delete();
      exp_q.push_back(8'(16'hEB90 / 256));
      exp_q.push_back(8'(16'hEB90 % 256));
      exp_q.push_back(8'(len / 256));
      exp_q.push_back(8'(len % 256));
      sum = (len / 256) + (len % 256);
      foreach (pay[i]) begin
         exp_q.push_back(pay[i]);
         sum += int'(pay[i]);
      end
`ifdef UART_FRAMER_CHECKSUM_EN
      exp_q.push_back(8'(sum % 256));
`endif
      exp_q.push_back(8'(16'h0D0A / 256));
      exp_q.push_back(8'(16'h0D0A % 256));

      s0 = start_cnt; e0 = end_cnt; w0 = wren_cnt; err0 = err_cnt;
      ev0 = end_viol; pv0 = pf_viol;
      cap_q.delete();
      first_wren_cyc = -1;
      start_cyc = -1;

      @(posedge clk); #1;
      pkt_start = 1'b1;
      pkt_len   = 16'(len);
      @(posedge clk); #1;
      pkt_start = 1'b0;

      idx = 0; gap_left = 0; pf_left = 0; cyc_f = 0;
      pf_done = 1'b0; done = 1'b0;
      while (!done && cyc_f < 4000) begin
         if (!pf_done && pf_after >= 0 && cap_q.size() >= pf_after) begin
            pf_left = 5;
            pf_done = 1'b1;
         end
         prog_full = (pf_left > 0);
         if (pf_left > 0) pf_left--;

         if (gap_left > 0) begin
            s_valid = 1'b0;
            gap_left--;
         end else begin
            s_valid = (idx < len);
         end
         s_data = (idx < len) ? pay[idx] : 8'h00;

         pkt_start = (cyc_f == mid_cyc);
         if (cyc_f == mid_cyc) pkt_len = 16'd7;

         @(negedge clk);
         acc = s_valid && s_ready;
         if (cyc_f == 3) check({tag, "_busy_mid"}, longint'(busy), 1);
         if (end_cnt != e0) done = 1'b1;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (gaps) gap_left = 3;
         end
         cyc_f++;

         if (abort_after >= 0 && idx == abort_after) begin
            rst_n = 1'b0;
            #1;
            check_all_zero({tag, "_rst"});
            check({tag, "_rst_no_end"}, longint'(end_cnt - e0), 0);
            s_valid = 1'b0;
            pkt_start = 1'b0;
            prog_full = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
      end

      s_valid = 1'b0;
      pkt_start = 1'b0;
      prog_full = 1'b0;
      check({tag, "_no_timeout"}, longint'(done), 1);
      repeat (3) @(posedge clk);
      #1;

      check({tag, "_starts"},   longint'(start_cnt - s0), 1);
      check({tag, "_ends"},     longint'(end_cnt - e0), 1);
      check({tag, "_n_bytes"},  longint'(cap_q.size()), longint'(exp_q.size()));
      check({tag, "_wren_cnt"}, longint'(wren_cnt - w0), longint'(exp_q.size()));
      check({tag, "_end_pos"},  longint'(end_pos), longint'(exp_q.size()));
      check({tag, "_end_align"}, longint'(end_viol - ev0), 0);
      check({tag, "_pf_stall"}, longint'(pf_viol - pv0), 0);
      check({tag, "_start_first"}, longint'(first_wren_cyc > start_cyc), 1);
      check({tag, "_busy_done"}, longint'(busy), 0);
      check({tag, "_no_err"},   longint'(err_cnt - err0), 0);
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), longint'(cap_q[i]), longint'(exp_q[i]));
      end
   endtask

   initial begin
      int s0, e0, w0, err0, b0;
      rst_n     = 1'b0;
      pkt_start = 1'b0;
      pkt_len   = '0;
      s_data    = '0;
      s_valid   = 1'b0;
      prog_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic L=3 frame, payload 01 02 03
      fixed_pay = '{8'h01, 8'h02, 8'h03};
      run_frame("basic", 3, 1'b0, -1, -1, -1);

      // Same frame with a back-pressure window after the 4th byte
      run_frame("pfull", 3, 1'b0, 4, -1, -1);
      fixed_pay.delete();

      // Illegal lengths: 0 and MAX_LEN+1
      s0 = start_cnt; e0 = end_cnt; w0 = wren_cnt; err0 = err_cnt; b0 = busy_cyc;
      @(posedge clk); #1;
      pkt_start = 1'b1; pkt_len = 16'd0;
      @(posedge clk); #1;
      pkt_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      pkt_start = 1'b1; pkt_len = 16'd1025;
      @(posedge clk); #1;
      pkt_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("badlen_err",   longint'(err_cnt - err0), 2);
      check("badlen_start", longint'(start_cnt - s0), 0);
      check("badlen_end",   longint'(end_cnt - e0), 0);
      check("badlen_wren",  longint'(wren_cnt - w0), 0);
      check("badlen_busy",  longint'(busy_cyc - b0), 0);

      // Reset in PAY after 2 payload bytes, then an L=1 frame
      run_frame("abort", 5, 1'b0, -1, -1, 2);
      repeat (2) @(posedge clk);
      fixed_pay = '{8'hAA};
      run_frame("after_rst", 1, 1'b0, -1, -1, -1);
      fixed_pay.delete();

      // L=7 with 3-cycle valid gaps and an ignored mid-frame start
      run_frame("gaps_mid", 7, 1'b1, -1, 8, -1);

      // Random length with gaps and back-pressure
      for (int k = 0; k < 3; k++) begin
         run_frame($sformatf("rand%0d", k), int'($urandom_range(2, 40)), 1'(k % 2),
                   int'($urandom_range(0, 12)), int'($urandom_range(4, 20)), -1);
      end

      // Largest legal length
      run_frame("maxlen", 1024, 1'b0, 100, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
